// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline stage register with flush, NOP bubbles and a saturating stall counter.
// Define PIPE_STAGE_HS_SKID_EN to add a one-entry skid buffer that registers in_ready.
module pipe_stage_hs #(
  parameter int CTRL_W = 24,
  parameter int DATA_W = 96,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              vld_q, vld_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

`ifdef PIPE_STAGE_HS_SKID_EN
  logic              sk_vld_q, sk_vld_d;
  logic [CTRL_W-1:0] sk_ctrl_q, sk_ctrl_d;
  logic [DATA_W-1:0] sk_data_q, sk_data_d;

  // Ready depends only on skid occupancy; flush forces it high since the beat is dropped anyway.
  assign in_ready = !sk_vld_q || flush;

  always_comb begin
    vld_d     = vld_q;
    ctrl_d    = ctrl_q;
    data_d    = data_q;
    sk_vld_d  = sk_vld_q;
    sk_ctrl_d = sk_ctrl_q;
    sk_data_d = sk_data_q;
    if (flush) begin
      vld_d    = 1'b0;
      ctrl_d   = '0;
      sk_vld_d = 1'b0;
    end else if (sk_vld_q) begin
      if (out_ready) begin
        vld_d    = 1'b1;
        ctrl_d   = sk_ctrl_q;
        data_d   = sk_data_q;
        sk_vld_d = 1'b0;
      end
    end else if (!vld_q || out_ready) begin
      vld_d  = in_valid;
      ctrl_d = in_valid ? in_ctrl : '0;
      if (in_valid) data_d = in_data;
    end else if (in_valid) begin
      sk_vld_d  = 1'b1;
      sk_ctrl_d = in_ctrl;
      sk_data_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sk_vld_q  <= 1'b0;
      sk_ctrl_q <= '0;
      sk_data_q <= '0;
    end else begin
      sk_vld_q  <= sk_vld_d;
      sk_ctrl_q <= sk_ctrl_d;
      sk_data_q <= sk_data_d;
    end
  end
`else
  assign in_ready = !vld_q || out_ready || flush;

  always_comb begin
    vld_d  = vld_q;
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (flush) begin
      vld_d  = 1'b0;
      ctrl_d = '0;
    end else if (!vld_q || out_ready) begin
      vld_d  = in_valid;
      ctrl_d = in_valid ? in_ctrl : '0;
      // Data holds when no entry loads, so an emptied stage does not toggle the data bus.
      if (in_valid) data_d = in_data;
    end
  end
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) cnt_d = '0;
    else if (vld_q && !out_ready && !flush && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = vld_q;
  assign out_ctrl  = ctrl_q;
  assign out_data  = data_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Randomized bench for pipe_stage_hs: stage modelled as an in-order FIFO of capacity 1 or 2.
module tb_pipe_stage_hs;
  localparam int CW = 24, DW = 32, NW = 4;
`ifdef PIPE_STAGE_HS_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, flush = 1'b0, cnt_clr = 1'b0;
  logic [CW-1:0] in_ctrl = '0, out_ctrl;
  logic [DW-1:0] in_data = '0, out_data;
  logic [NW-1:0] stall_cnt;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  logic [CW+DW-1:0] mq[$];
  int mcnt = 0;

  always #5 clk = ~clk;

  pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .flush(flush), .cnt_clr(cnt_clr),
    .stall_cnt(stall_cnt));

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit model_rdy();
    if (SKID) return (mq.size() < 2) || flush;
    return (mq.size() == 0) || out_ready || flush;
  endfunction

  always @(posedge rst) begin
    mq.delete();
    mcnt = 0;
  end

  // Compare against the FIFO model mid-cycle, then advance the model at the clock edge.
  always begin
    bit mv, rdy;
    @(negedge clk);
    #2;
    if (chk_en) begin
      mv = mq.size() > 0;
      chk("out_valid", 64'(out_valid), 64'(mv));
      chk("out_ctrl", 64'(out_ctrl), mv ? 64'(mq[0][CW+DW-1:DW]) : 64'd0);
      if (mv) chk("out_data", 64'(out_data), 64'(mq[0][DW-1:0]));
      chk("in_ready", 64'(in_ready), 64'(model_rdy()));
      chk("stall_cnt", 64'(stall_cnt), 64'(mcnt));
    end
    @(posedge clk);
    if (!rst) begin
      rdy = model_rdy();
      if (cnt_clr) mcnt = 0;
      else if (mq.size() > 0 && !out_ready && !flush && mcnt < (1 << NW) - 1) mcnt++;
      if (flush) mq.delete();
      else begin
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (in_valid && rdy) mq.push_back({in_ctrl, in_data});
      end
    end
  end

  task automatic step(input bit iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input bit ordy, input bit fl, input bit clr);
    @(negedge clk);
    in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl; cnt_clr = clr;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    #3;
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_ctrl", 64'(out_ctrl), 0);
    chk("rst_data", 64'(out_data), 0);
    chk("rst_cnt", 64'(stall_cnt), 0);
    chk("rst_ready", 64'(in_ready), 1);

    // streaming: each entry visible one cycle after acceptance
    for (int i = 0; i < 8; i++) begin
      step(1'b1, CW'(i + 1), DW'(i), 1'b1, 1'b0, 1'b0);
      #3;
      if (i > 0) begin
        chk("stream_valid", 64'(out_valid), 1);
        chk("stream_ctrl", 64'(out_ctrl), 64'(i));
        chk("stream_data", 64'(out_data), 64'(i - 1));
      end
      chk("stream_cnt", 64'(stall_cnt), 0);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0); #3;
    chk("stream_last_ctrl", 64'(out_ctrl), 8);
    chk("stream_last_data", 64'(out_data), 7);

    // async reset while stalled
    step(1'b1, 24'hABCDEF, 32'h1234, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("pre_rst_ctrl", 64'(out_ctrl), 64'hABCDEF);
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 0);
    chk("arst_ctrl", 64'(out_ctrl), 0);
    chk("arst_data", 64'(out_data), 0);
    chk("arst_cnt", 64'(stall_cnt), 0);
    chk("arst_ready", 64'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    // stall 5 cycles with a new entry offered
    step(1'b1, 24'h11, 32'hA1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 24'h22, 32'hA2, 1'b0, 1'b0, 1'b0);
      #3;
      chk("stall_ctrl", 64'(out_ctrl), 64'h11);
      chk("stall_data", 64'(out_data), 64'hA1);
      chk("stall_ready", 64'(in_ready), 64'(SKID && i == 0));
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0); #3;
    chk("stall_cnt5", 64'(stall_cnt), 5);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0); #3;
    chk("after_stall_valid", 64'(out_valid), 64'(SKID));
    chk("after_stall_ctrl", 64'(out_ctrl), SKID ? 64'h22 : 64'h0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // flush during stall
    step(1'b1, 24'h33, 32'h33, 1'b0, 1'b0, 1'b0);
    step(1'b1, 24'h44, 32'h44, 1'b0, 1'b0, 1'b0);
    step(1'b1, 24'h5, 32'h5, 1'b0, 1'b1, 1'b0); #3;
    chk("flush_ready", 64'(in_ready), 1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0); #3;
      chk("flush_valid", 64'(out_valid), 0);
      chk("flush_ctrl", 64'(out_ctrl), 0);
    end

    // saturation, then clear coinciding with a stall
    step(1'b1, 24'h66, 32'h66, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1); #3;
    chk("sat_cnt", 64'(stall_cnt), 15);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0); #3;
    chk("clr_cnt", 64'(stall_cnt), 0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // random drain/fill with back-pressure pulses, rare flush and clear
    for (int i = 0; i < 3000; i++)
      step(($urandom % 8) != 0, CW'(i + 1), $urandom, ($urandom % 4) != 0,
           ($urandom % 50) == 0, ($urandom % 40) == 0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); #3;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_hs.md
# pipe_stage_hs

Parametrised, handshaked pipeline stage register, the successor to the fixed per-stage flop banks between IF/ID/EX/MEM/WB. It carries an opaque control bundle and a data bundle with a valid/ready handshake. Stall and flush are built in: a flushed or reset stage presents an all-zero control bundle, which decodes as a NOP bubble. An optional skid buffer breaks the combinational ready path, and a saturating counter records back-pressure cycles for performance analysis.

## Interface
- CTRL_W, default 24: control bundle width (memWrite, regSrc, aluOp, ...); zero means NOP.
- DATA_W, default 96: data bundle width (instr, pc_inc, operands, immediates).
- CNT_W, default 16: stall counter width.

- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage accepts an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  downstream entry present.
- out_ready  in  1  downstream accepts this cycle (low = stall).
- out_ctrl  out  CTRL_W  registered control bundle.
- out_data  out  DATA_W  registered data bundle.
- flush  in  1  synchronous flush: discard all held and incoming entries.
- cnt_clr  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

## Operation
- Transfer in: in_valid && in_ready at a clock edge. Transfer out: out_valid && out_ready at a clock edge.
- Main register: out_valid, out_ctrl, out_data. It loads on a transfer in when it is empty or is draining in the same cycle.
- Bubble rule:
  - Whenever out_valid=0, out_ctrl=0.
  - out_data is don't-care when out_valid=0 and keeps its previous value (no toggling).
- Flush:
  - Highest priority. At the next edge out_valid=0, out_ctrl=0, and the skid entry (if present) is invalidated.
  - Any in_valid entry in the flush cycle is dropped.
  - in_ready=1 during flush.
  - stall_cnt is unaffected by flush.
- stall_cnt:
  - Increments when out_valid && !out_ready && !flush.
  - Holds at 2^CNT_W-1.
  - cnt_clr has priority over increment, and sets the count to 0 at the next edge.
- Simultaneous drain and fill: the old entry leaves and the new entry loads in the same edge. Throughput is 1 entry/cycle.
- Reset (asynchronous, any cycle, including mid-stall):
  - out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0.
  - Skid buffer empty; in_ready=1 after reset (both modes).

## Timing
- Latency: 1 cycle from transfer in to out_valid, both modes, when the stage is not stalled.
- Without skid: in_ready = !out_valid || out_ready. This is combinational and passes through from out_ready.
- With skid: in_ready is a registered signal.
- out_valid, out_ctrl and out_data are always registered; there is no combinational in→out path.
- Handshake rule: once asserted, out_valid stays high and out_ctrl/out_data stay stable until transfer out or flush.

## Configuration
- PIPE_STAGE_HS_SKID_EN defined:
  - Adds a one-entry skid register. in_ready = !skid_valid (registered).
  - A transfer in while the main register is held (out_valid && !out_ready) goes to the skid register.
  - On the next out_ready, skid moves into main and skid_valid clears.
  - Capacity is 2 entries. There are no combinational paths from out_ready.
- Not defined:
  - No skid register; capacity is 1 entry.
  - in_ready is the combinational expression given under Timing.
  - Behaviour is otherwise identical.

## Test plan
- Reset mid-stream: load ctrl=0xABCDEF, hold out_ready=0, then assert rst asynchronously between edges. out_valid, out_ctrl, out_data and stall_cnt go to 0 immediately; in_ready=1.
- Streaming: 8 back-to-back entries (data=i, ctrl=i+1) with out_ready=1. Each appears 1 cycle later, one per cycle, in order, with stall_cnt=0.
- Stall:
  - Hold out_ready=0 for 5 cycles with an entry loaded. out_ctrl/out_data stay stable and stall_cnt=5.
  - Without skid, in_ready=0 for all 5 cycles.
  - With skid, exactly one extra entry is accepted and delivered after the first once out_ready=1.
- Flush during stall: a valid entry is held and in_valid=1 with ctrl=0x5. Assert flush for 1 cycle. Next cycle out_valid=0 and out_ctrl=0; the incoming entry never appears; the skid entry (if present) is dropped.
- Counter saturation: CNT_W=4 with 20 stall cycles gives stall_cnt=15. cnt_clr asserted together with a stall gives 0 on the next cycle.
- Simultaneous drain and fill with out_ready=1 and in_valid=1 every cycle, plus random out_ready=0 pulses. The scoreboard sees no loss or duplication, and ctrl=0 whenever out_valid=0.
